// File: rtl/ebr_stream_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ebr_stream_pkg
// Purpose  : Shared types and defaults for the EBR byte-stream master.
//            State encoding, default opcodes and bytes-per-word.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package ebr_stream_pkg;

  localparam int         ADDR_W_DEF   = 8;
  localparam logic [7:0] OP_WRITE_DEF = 8'h01;
  localparam logic [7:0] OP_READ_DEF  = 8'h02;
  localparam int         WORD_BYTES   = 2;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_CNT       = 4'd2,
    S_WR_HI     = 4'd3,
    S_WR_LO     = 4'd4,
    S_WR_COMMIT = 4'd5,
    S_RD_ISSUE  = 4'd6,
    S_RD_WAIT   = 4'd7,
    S_RD_HI     = 4'd8,
    S_RD_LO     = 4'd9
  } state_e;

  // States in which the block is willing to take a byte from the rx link.
  function automatic logic rx_state(input state_e s);
    return s inside {S_IDLE, S_ADDR, S_CNT, S_WR_HI, S_WR_LO};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ebr_stream_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ebr_stream_master_if
// Purpose  : Bundles the rx byte link, tx byte link and EBR RAM port driven
//            by ebr_stream_master.
// Ports    : rx_valid_i/rx_data_i/rx_ready_o  - inbound command/data bytes
//            tx_valid_o/tx_data_o/tx_ready_i  - outbound read-data bytes
//            ram_clk_en_o/ram_wr_en_o/ram_addr_o/ram_wr_data_o/ram_rd_data_i
//                                              - 256x16 EBR port
//            Directions (_i/_o) are as seen from the master.
// Revision : 1.0 - initial release
// ============================================================================
interface ebr_stream_master_if #(
  parameter int ADDR_W = 8
) ();
  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              rx_ready_o;
  logic              tx_valid_o;
  logic [7:0]        tx_data_o;
  logic              tx_ready_i;
  logic              ram_clk_en_o;
  logic              ram_wr_en_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [15:0]       ram_wr_data_o;
  logic [15:0]       ram_rd_data_i;

  modport master (
    input  rx_valid_i, rx_data_i, tx_ready_i, ram_rd_data_i,
    output rx_ready_o, tx_valid_o, tx_data_o,
           ram_clk_en_o, ram_wr_en_o, ram_addr_o, ram_wr_data_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, tx_ready_i, ram_rd_data_i,
    input  rx_ready_o, tx_valid_o, tx_data_o,
           ram_clk_en_o, ram_wr_en_o, ram_addr_o, ram_wr_data_o
  );
endinterface
`default_nettype wire

// File: rtl/ebr_stream_master.sv
`default_nettype none
// ============================================================================
// Module   : ebr_stream_master
// Purpose  : Turns a byte command stream [op][addr][count][data...] into
//            16-bit EBR word writes/reads and streams read words back as
//            bytes, MSB first. Sole master of the RAM port.
// Ports    : clk_i  - system clock
//            rst_i  - asynchronous active-high reset
//            bus    - rx/tx byte links and RAM port (master modport)
//            busy_o - high while a frame is in progress
//            err_o  - one-cycle pulse on an unknown opcode
// Revision : 1.0 - initial release
// ============================================================================
module ebr_stream_master
  import ebr_stream_pkg::*;
#(
  parameter int         ADDR_W     = ADDR_W_DEF,
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] OP_WRITE   = OP_WRITE_DEF,
  parameter logic [7:0] OP_READ    = OP_READ_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ebr_stream_master_if.master  bus,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              op_wr_q;
  logic [7:0]        data_hi_q;
  logic [15:0]       hold_q;
  logic [WAIT_W-1:0] wait_q;

  logic              rx_ready_q, tx_valid_q, ram_clk_en_q, ram_wr_en_q;
  logic [7:0]        tx_data_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [15:0]       ram_wr_data_q;
  logic              busy_q, err_q;

  logic rx_acc, tx_acc, op_known, last_word, wait_done;

  assign rx_acc    = bus.rx_valid_i & rx_ready_q;
  assign tx_acc    = tx_valid_q & bus.tx_ready_i;
  assign op_known  = (bus.rx_data_i == OP_WRITE) || (bus.rx_data_i == OP_READ);
  assign last_word = (cnt_q == '0);
  assign wait_done = (wait_q == WAIT_W'(RD_LATENCY - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (rx_acc && op_known) state_d = S_ADDR;
      S_ADDR:  if (rx_acc) begin
                 addr_d  = ADDR_W'(bus.rx_data_i);
                 state_d = S_CNT;
               end
      S_CNT:   if (rx_acc) begin
                 cnt_d   = ADDR_W'(bus.rx_data_i);
                 state_d = op_wr_q ? S_WR_HI : S_RD_ISSUE;
               end
      S_WR_HI: if (rx_acc) state_d = S_WR_LO;
      S_WR_LO: if (rx_acc) state_d = S_WR_COMMIT;
      S_WR_COMMIT: begin
        addr_d = addr_q + 1'b1;
        if (last_word) state_d = S_IDLE;
        else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = S_WR_HI;
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  if (wait_done) state_d = S_RD_HI;
      S_RD_HI:    if (tx_acc) state_d = S_RD_LO;
      S_RD_LO:    if (tx_acc) begin
                    addr_d = addr_q + 1'b1;
                    if (last_word) state_d = S_IDLE;
                    else begin
                      cnt_d   = cnt_q - 1'b1;
                      state_d = S_RD_ISSUE;
                    end
                  end
      default:    state_d = S_IDLE;
    endcase
  end

  // All outputs are registered copies of what the next state demands, so
  // they line up with state_q one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      data_hi_q     <= '0;
      hold_q        <= '0;
      wait_q        <= '0;
      rx_ready_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      ram_clk_en_q  <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;

      if (state_q == S_IDLE && rx_acc) op_wr_q <= (bus.rx_data_i == OP_WRITE);
      if (state_q == S_WR_HI && rx_acc) data_hi_q <= bus.rx_data_i;
      // Low byte goes straight into the write-data register as it arrives.
      if (state_q == S_WR_LO && rx_acc) ram_wr_data_q <= {data_hi_q, bus.rx_data_i};

      err_q  <= (state_q == S_IDLE) && rx_acc && !op_known;
      wait_q <= (state_q == S_RD_WAIT) ? wait_q + 1'b1 : '0;

      rx_ready_q   <= rx_state(state_d);
      busy_q       <= (state_d != S_IDLE);
      ram_clk_en_q <= (state_d == S_WR_COMMIT) || (state_d == S_RD_ISSUE);
      ram_wr_en_q  <= (state_d == S_WR_COMMIT);
      if ((state_d == S_WR_COMMIT) || (state_d == S_RD_ISSUE)) ram_addr_q <= addr_d;

      tx_valid_q <= (state_d == S_RD_HI) || (state_d == S_RD_LO);
      if (state_q == S_RD_WAIT && state_d == S_RD_HI) begin
        hold_q    <= bus.ram_rd_data_i;
        tx_data_q <= bus.ram_rd_data_i[15:8];
      end else if (state_q == S_RD_HI && state_d == S_RD_LO) begin
        tx_data_q <= hold_q[7:0];
      end
    end
  end

  assign bus.rx_ready_o    = rx_ready_q;
  assign bus.tx_valid_o    = tx_valid_q;
  assign bus.tx_data_o     = tx_data_q;
  assign bus.ram_clk_en_o  = ram_clk_en_q;
  assign bus.ram_wr_en_o   = ram_wr_en_q;
  assign bus.ram_addr_o    = ram_addr_q;
  assign bus.ram_wr_data_o = ram_wr_data_q;
  assign busy_o            = busy_q;
  assign err_o             = err_q;

endmodule
`default_nettype wire
